// File: rtl/pmem_read_arbiter_pkg.sv
// Shared types, access-size encodings and the alignment/size legality helper
// for the physical-memory read arbiter.
package pmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic [2:0] LEN_B = 3'd1;
   localparam logic [2:0] LEN_H = 3'd2;
   localparam logic [2:0] LEN_W = 3'd4;

   localparam int PERF_W = 32;

   // Only byte, halfword and word sizes exist, and each must be naturally aligned.
   // The two low address bits are all that alignment needs.
   function automatic logic len_legal(input logic [1:0] addr_lo, input logic [2:0] len);
      logic ok;
      case (len)
         LEN_B:   ok = 1'b1;
         LEN_H:   ok = ~addr_lo[0];
         LEN_W:   ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/pmem_read_arbiter_if.sv
// Requester-facing bus of the read arbiter: per-requester request and response
// valid/ready channels plus the shared response data/error.
interface pmem_read_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
);

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ*3-1:0]  req_len;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [DW-1:0]         rsp_data;
   logic                  rsp_err;

   // Requester side (fetch / load units)
   modport master (
      output req_valid, req_addr, req_len, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_addr, req_len, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/pmem_read_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first asserted request at or
// after the pointer, searching in wrap-around order.
module rr_picker #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_grant_idx
);

   logic [IW-1:0] w_cand_idx [N];
   logic [N-1:0]  w_cand_req;

   // Candidate gi is the requester gi positions after the pointer.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign w_cand_idx[gi] = IW'((int'(i_ptr) + gi) % N);
      assign w_cand_req[gi] = i_req[w_cand_idx[gi]];
   end

   // Lowest rotated position wins; grant is empty when nobody requests.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_cand_req[k]) begin
            o_grant_idx = w_cand_idx[k];
         end
      end
      if (|i_req) begin
         o_grant[o_grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/pmem_read_arbiter.sv
// Physical-memory read arbiter: shares one DPI read port among NUM_REQ
// requesters with round-robin grant and a single outstanding access.
// Optional feature macro: PMEM_ARB_PERF_EN adds per-requester grant and
// wait-cycle counters (perf_grant_cnt / perf_wait_cnt).
module pmem_read_arbiter
   import pmem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   pmem_read_arbiter_if.slave      s_bus,
   output logic                    mem_en_o,
   output logic [AW-1:0]           mem_addr_o,
   output logic [31:0]             mem_len_o,
   input  logic [DW-1:0]           mem_data_i
`ifdef PMEM_ARB_PERF_EN
   ,
   output logic [NUM_REQ*PERF_W-1:0] perf_grant_cnt,
   output logic [NUM_REQ*PERF_W-1:0] perf_wait_cnt
`endif
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e          r_state;
   arb_state_e          w_next_state;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IW-1:0]       w_grant_idx;
   logic [NUM_REQ-1:0]  w_req_ready;
   logic [NUM_REQ-1:0]  w_rsp_valid;

   logic [AW-1:0]       w_addr_arr [NUM_REQ];
   logic [2:0]          w_len_arr  [NUM_REQ];
   logic [AW-1:0]       w_sel_addr;
   logic [2:0]          w_sel_len;

   logic                w_accept;
   logic                w_legal;
   logic                w_rsp_hs;

   logic [IW-1:0]       r_owner;
   logic [IW-1:0]       r_rr_ptr;
   logic [AW-1:0]       r_addr;
   logic [2:0]          r_len;
   logic [DW-1:0]       r_rsp_data;
   logic                r_rsp_err;

   // Unpack the per-requester address and size fields.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = s_bus.req_addr[gi*AW +: AW];
      assign w_len_arr[gi]  = s_bus.req_len[gi*3 +: 3];
   end

   rr_picker #(
      .N (NUM_REQ)
   ) u_picker (
      .i_req       (s_bus.req_valid),
      .i_ptr       (r_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx)
   );

   assign w_sel_addr = w_addr_arr[w_grant_idx];
   assign w_sel_len  = w_len_arr[w_grant_idx];
   assign w_legal    = len_legal(w_sel_addr[1:0], w_sel_len);

   // Ready is only ever raised in IDLE, so any valid&ready is an acceptance.
   assign w_accept   = |(s_bus.req_valid & w_req_ready);
   assign w_rsp_hs   = (r_state == RESP) && s_bus.rsp_ready[r_owner];

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; illegal accesses bypass the memory and answer at once.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = w_legal ? ISSUE : RESP;
         ISSUE:   w_next_state = WAIT;
         WAIT:    w_next_state = RESP;
         RESP:    if (w_rsp_hs) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State-decoded outputs; ready is held low while reset is asserted.
   always_comb begin
      w_req_ready = '0;
      w_rsp_valid = '0;
      mem_en_o    = 1'b0;
      case (r_state)
         IDLE:    if (reset_n) w_req_ready = w_grant;
         ISSUE:   mem_en_o = 1'b1;
         RESP:    w_rsp_valid[r_owner] = 1'b1;
         default: ;
      endcase
   end

   // Latch owner, address and size of the accepted request.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_owner <= '0;
         r_addr  <= '0;
         r_len   <= '0;
      end else if (w_accept) begin
         r_owner <= w_grant_idx;
         r_addr  <= w_sel_addr;
         r_len   <= w_sel_len;
      end
   end

   // Response payload: error on illegal accept, memory data captured in WAIT only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else if (w_accept && !w_legal) begin
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b1;
      end else if (r_state == WAIT) begin
         r_rsp_data <= mem_data_i;
         r_rsp_err  <= 1'b0;
      end
   end

   // Advance the round-robin pointer past the owner once its response is taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= '0;
      end else if (w_rsp_hs) begin
         r_rr_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
      end
   end

   assign s_bus.req_ready = w_req_ready;
   assign s_bus.rsp_valid = w_rsp_valid;
   assign s_bus.rsp_data  = r_rsp_data;
   assign s_bus.rsp_err   = r_rsp_err;
   assign mem_addr_o      = r_addr;
   assign mem_len_o       = {29'd0, r_len};

`ifdef PMEM_ARB_PERF_EN
   logic [PERF_W-1:0] r_perf_grant [NUM_REQ];
   logic [PERF_W-1:0] r_perf_wait  [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      // Saturating count of grants to this requester.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_perf_grant[gi] <= '0;
         end else if (w_accept && w_grant[gi] && (r_perf_grant[gi] != '1)) begin
            r_perf_grant[gi] <= r_perf_grant[gi] + PERF_W'(1);
         end
      end

      // Saturating count of cycles this requester waited with valid high.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_perf_wait[gi] <= '0;
         end else if (s_bus.req_valid[gi] && !w_req_ready[gi] && (r_perf_wait[gi] != '1)) begin
            r_perf_wait[gi] <= r_perf_wait[gi] + PERF_W'(1);
         end
      end

      assign perf_grant_cnt[gi*PERF_W +: PERF_W] = r_perf_grant[gi];
      assign perf_wait_cnt[gi*PERF_W +: PERF_W]  = r_perf_wait[gi];
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule
